dmem_arbiter: RTL and testbench

//  Two-requester arbiter/sequencer for the single data-memory port behind the RISCV core.

---
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer for the single data-memory port (core load/store and loader).
// Optional ack watchdog enabled by defining DMEM_ARB_TIMEOUT_EN.
//
//  state | meaning
//  IDLE  | no transaction; grant the next requester and latch its command
//  BUSY  | mem_req held from latched command, waiting for mem_ack (or watchdog)
//  RESP  | one-cycle done pulse to the owner with captured read data
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_done,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_done,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  owner,
    output logic                  err
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state;
    logic                  last;
    logic                  grant_m1;
    logic                  tmo_hit;
    logic [DATA_WIDTH-1:0] resp_data;

    // On a tie, round-robin hands the port to whichever master was not served last.
    always_comb begin
        grant_m1 = 1'b0;
        if (m0_req && m1_req) begin
            grant_m1 = (FIXED_PRIO != 0) ? 1'b0 : ~last;
        end else begin
            grant_m1 = m1_req;
        end
    end

    assign resp_data = (mem_ack && !mem_we) ? mem_rdata : '0;

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] tmo_cnt;

    // Hit on the TIMEOUT-th BUSY cycle, so RESP follows exactly TIMEOUT BUSY cycles.
    assign tmo_hit = (state == BUSY) && !mem_ack && (tmo_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (state == BUSY && !mem_ack) begin
                tmo_cnt <= tmo_cnt + CW'(1);
            end else begin
                tmo_cnt <= '0;
            end
            if (tmo_hit) begin
                err <= 1'b1;
            end
        end
    end
`else
    // No watchdog: BUSY waits for mem_ack forever; TIMEOUT only matters in the other build.
    assign tmo_hit = 1'b0 & (TIMEOUT > 0);
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            owner     <= 1'b0;
            busy      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            m0_done   <= 1'b0;
            m1_done   <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        owner     <= grant_m1;
                        mem_we    <= grant_m1 ? m1_we    : m0_we;
                        mem_addr  <= grant_m1 ? m1_addr  : m0_addr;
                        mem_wdata <= grant_m1 ? m1_wdata : m0_wdata;
                        mem_req   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack || tmo_hit) begin
                        mem_req  <= 1'b0;
                        last     <= owner;
                        m0_done  <= ~owner;
                        m1_done  <= owner;
                        m0_rdata <= owner ? '0 : resp_data;
                        m1_rdata <= owner ? resp_data : '0;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    m0_done  <= 1'b0;
                    m1_done  <= 1'b0;
                    m0_rdata <= '0;
                    m1_rdata <= '0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin and a fixed-priority instance, each with
// per-master request drivers, a latency-programmable memory responder and a scoreboard.
module tb_dmem_arbiter;

    localparam int AW  = 9;
    localparam int DW  = 32;
    localparam int TMO = 16;

    typedef struct packed {
        logic          m;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req      [2][2];
    logic          we_in    [2][2];
    logic [AW-1:0] addr_in  [2][2];
    logic [DW-1:0] wdata_in [2][2];
    logic          done     [2][2];
    logic [DW-1:0] rdata_out[2][2];
    logic          mem_req  [2];
    logic          mem_we   [2];
    logic [AW-1:0] mem_addr [2];
    logic [DW-1:0] mem_wdata[2];
    logic          mem_ack  [2];
    logic          man_ack  [2];
    logic [DW-1:0] mem_rdata[2];
    logic          busy     [2];
    logic          owner    [2];
    logic          err      [2];
    logic          mem_en   [2];
    int            lat      [2];
    logic [AW-1:0] addr_mask;
    logic [DW-1:0] wdata_mask;

    txn_t drv_q[2][2][$];
    txn_t exp_q[2][$];

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(0), .TIMEOUT(TMO)) u_rr (
        .clk(clk), .rst(rst),
        .m0_req(req[0][0]), .m0_we(we_in[0][0]), .m0_addr(addr_in[0][0]), .m0_wdata(wdata_in[0][0]),
        .m0_done(done[0][0]), .m0_rdata(rdata_out[0][0]),
        .m1_req(req[0][1]), .m1_we(we_in[0][1]), .m1_addr(addr_in[0][1] ^ addr_mask),
        .m1_wdata(wdata_in[0][1] ^ wdata_mask),
        .m1_done(done[0][1]), .m1_rdata(rdata_out[0][1]),
        .mem_req(mem_req[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_ack(mem_ack[0] | man_ack[0]), .mem_rdata(mem_rdata[0]),
        .busy(busy[0]), .owner(owner[0]), .err(err[0])
    );

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1), .TIMEOUT(TMO)) u_fp (
        .clk(clk), .rst(rst),
        .m0_req(req[1][0]), .m0_we(we_in[1][0]), .m0_addr(addr_in[1][0]), .m0_wdata(wdata_in[1][0]),
        .m0_done(done[1][0]), .m0_rdata(rdata_out[1][0]),
        .m1_req(req[1][1]), .m1_we(we_in[1][1]), .m1_addr(addr_in[1][1]), .m1_wdata(wdata_in[1][1]),
        .m1_done(done[1][1]), .m1_rdata(rdata_out[1][1]),
        .mem_req(mem_req[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_ack(mem_ack[1] | man_ack[1]), .mem_rdata(mem_rdata[1]),
        .busy(busy[1]), .owner(owner[1]), .err(err[1])
    );

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return (a == 9'h012) ? 32'hDEADBEEF : {7'h0, a, 16'hC3A5};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int i, input logic m, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic tmo);
        txn_t t;
        t.m     = m;
        t.we    = we;
        t.addr  = a;
        t.wdata = wd;
        t.rdata = (we || tmo) ? '0 : mem_fn(a);
        drv_q[i][m].push_back(t);
        exp_q[i].push_back(t);
    endtask

    task automatic wait_drain(input int i, input int budget);
        int n;
        n = 0;
        while ((exp_q[i].size() > 0 || drv_q[i][0].size() > 0 || drv_q[i][1].size() > 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("drain%0d", i), exp_q[i].size() + drv_q[i][0].size() + drv_q[i][1].size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_mem_req(input int i, input string tag);
        int n;
        n = 0;
        while (!mem_req[i] && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk(tag, mem_req[i], 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        for (genvar gm = 0; gm < 2; gm++) begin : g_mst
            // Requester: holds req with stable fields until its done, then loads the next or drops.
            initial begin
                txn_t t;
                req[gi][gm] = 1'b0;
                we_in[gi][gm] = 1'b0;
                addr_in[gi][gm] = '0;
                wdata_in[gi][gm] = '0;
                forever begin
                    @(negedge clk);
                    if (req[gi][gm]) begin
                        if (done[gi][gm]) begin
                            void'(drv_q[gi][gm].pop_front());
                            if (drv_q[gi][gm].size() > 0) begin
                                t = drv_q[gi][gm][0];
                                we_in[gi][gm] = t.we;
                                addr_in[gi][gm] = t.addr;
                                wdata_in[gi][gm] = t.wdata;
                            end else begin
                                req[gi][gm] = 1'b0;
                            end
                        end else if (drv_q[gi][gm].size() == 0) begin
                            req[gi][gm] = 1'b0;
                        end
                    end else if (drv_q[gi][gm].size() > 0) begin
                        t = drv_q[gi][gm][0];
                        we_in[gi][gm] = t.we;
                        addr_in[gi][gm] = t.addr;
                        wdata_in[gi][gm] = t.wdata;
                        req[gi][gm] = 1'b1;
                    end
                end
            end
        end

        // Memory: acks lat[gi] cycles after seeing mem_req; random data when not acking.
        initial begin
            int cnt;
            cnt = 0;
            mem_ack[gi] = 1'b0;
            mem_rdata[gi] = '0;
            forever begin
                @(negedge clk);
                if (!mem_en[gi]) begin
                    cnt = 0;
                    mem_ack[gi] = 1'b0;
                    mem_rdata[gi] = $urandom;
                end else if (mem_ack[gi]) begin
                    cnt = 0;
                    mem_ack[gi] = 1'b0;
                    mem_rdata[gi] = $urandom;
                end else if (mem_req[gi] && cnt >= lat[gi]) begin
                    mem_ack[gi] = 1'b1;
                    mem_rdata[gi] = mem_fn(mem_addr[gi]);
                end else begin
                    cnt = mem_req[gi] ? cnt + 1 : 0;
                    mem_rdata[gi] = $urandom;
                end
            end
        end

        // Scoreboard: command check on mem_req rise, result check on done.
        initial begin
            logic prev_req;
            txn_t e;
            prev_req = 1'b0;
            forever begin
                @(negedge clk);
                if (mem_req[gi] && !prev_req) begin
                    chk($sformatf("cmd_expected%0d", gi), exp_q[gi].size() > 0, 1'b1);
                    if (exp_q[gi].size() > 0) begin
                        e = exp_q[gi][0];
                        chk($sformatf("cmd%0d", gi), {mem_we[gi], mem_addr[gi], mem_wdata[gi]},
                            {e.we, e.addr, e.wdata});
                        chk($sformatf("grant_owner%0d", gi), owner[gi], e.m);
                    end
                end
                if (done[gi][0] || done[gi][1]) begin
                    chk($sformatf("done_expected%0d", gi), exp_q[gi].size() > 0, 1'b1);
                    if (exp_q[gi].size() > 0) begin
                        e = exp_q[gi].pop_front();
                        chk($sformatf("done_sel%0d", gi), {done[gi][1], done[gi][0]}, e.m ? 2'b10 : 2'b01);
                        chk($sformatf("rdata%0d", gi), rdata_out[gi][e.m], e.rdata);
                    end
                end
                prev_req = mem_req[gi];
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b0;
        addr_mask = '0;
        wdata_mask = '0;
        man_ack[0] = 1'b0;
        man_ack[1] = 1'b0;
        mem_en[0] = 1'b1;
        mem_en[1] = 1'b1;
        lat[0] = 2;
        lat[1] = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", busy[i], 1'b0);
            chk("rst_outs", {mem_req[i], mem_we[i], mem_addr[i], mem_wdata[i], done[i][0], done[i][1],
                             owner[i], err[i]}, '0);
            chk("rst_rdata", {rdata_out[i][0], rdata_out[i][1]}, '0);
        end

        // Single read, ack two cycles after mem_req, with latency check.
        @(posedge clk);
        #1 push(0, 1'b0, 1'b0, 9'h012, 32'h0, 1'b0);
        @(negedge clk);
        chk("lat_idle", mem_req[0], 1'b0);
        @(negedge clk);
        chk("lat_req", {mem_req[0], busy[0]}, 2'b11);
        wait_drain(0, 50);

        // Both masters from reset: alternating order, then again with both still held.
        do_reset();
        lat[0] = 0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            push(0, 1'b0, 1'b0, AW'(9'h020 + k), 32'h0, 1'b0);
            push(0, 1'b1, 1'b1, AW'(9'h100 + k), DW'(32'hA000 + k), 1'b0);
        end
        wait_drain(0, 200);
        lat[0] = 1;
        @(posedge clk);
        #1;
        for (int k = 3; k < 5; k++) begin
            push(0, 1'b0, 1'b1, AW'(9'h020 + k), DW'(32'h5000 + k), 1'b0);
            push(0, 1'b1, 1'b0, AW'(9'h100 + k), 32'h0, 1'b0);
        end
        wait_drain(0, 200);

        // m1 write whose inputs change while BUSY: latched command must stay.
        lat[0] = 4;
        @(posedge clk);
        #1 push(0, 1'b1, 1'b1, 9'h1FF, 32'h0000_00A5, 1'b0);
        wait_mem_req(0, "m1_wr_busy");
        addr_mask = 9'h154;
        wdata_mask = 32'hFFFF_0000;
        @(negedge clk);
        @(negedge clk);
        chk("hold_cmd", {mem_we[0], mem_addr[0], mem_wdata[0]}, {1'b1, 9'h1FF, 32'h0000_00A5});
        wait_drain(0, 50);
        addr_mask = '0;
        wdata_mask = '0;

        // Reset in BUSY, then a stray ack: nothing may complete.
        mem_en[0] = 1'b0;
        @(posedge clk);
        #1 push(0, 1'b0, 1'b0, 9'h033, 32'h0, 1'b0);
        wait_mem_req(0, "rst_busy_entry");
        @(posedge clk);
        #1;
        rst = 1'b0;
        drv_q[0][0].delete();
        exp_q[0].delete();
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_req", {mem_req[0], busy[0]}, 2'b00);
        @(posedge clk);
        #1 man_ack[0] = 1'b1;
        @(posedge clk);
        #1 man_ack[0] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("stray_ack", {done[0][0], done[0][1], busy[0], mem_req[0]}, 4'b0000);
        end
        mem_en[0] = 1'b1;

        // Fixed priority: m0 keeps winning while it requests, m1 only afterwards.
        @(posedge clk);
        #1;
        push(1, 1'b0, 1'b0, 9'h040, 32'h0, 1'b0);
        push(1, 1'b0, 1'b1, 9'h041, 32'h55, 1'b0);
        push(1, 1'b0, 1'b0, 9'h042, 32'h0, 1'b0);
        push(1, 1'b1, 1'b0, 9'h0AA, 32'h0, 1'b0);
        wait_drain(1, 200);

`ifdef DMEM_ARB_TIMEOUT_EN
        begin
            int n;
            mem_en[0] = 1'b0;
            @(posedge clk);
            #1 push(0, 1'b0, 1'b0, 9'h077, 32'h0, 1'b1);
            wait_mem_req(0, "tmo_entry");
            n = 0;
            while (mem_req[0] && n < 40) begin
                n++;
                @(negedge clk);
            end
            chk("tmo_cycles", n, TMO);
            wait_drain(0, 20);
            chk("tmo_err", err[0], 1'b1);
            mem_en[0] = 1'b1;
        end
`else
        chk("err_tied0", err[0], 1'b0);
        chk("err_tied1", err[1], 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
